// File: rtl/riscv_instr_aligner_pkg.sv
// Shared fetch-side definitions: aligner state encoding and the RVC length decode
// that the pre-decoder and compressed decoder also rely on.
package riscv_instr_aligner_pkg;

    typedef enum logic [1:0] {
        ALIGNED = 2'd0,
        MIS16   = 2'd1,
        MIS32   = 2'd2,
        BRMIS   = 2'd3
    } align_state_e;

    // Any halfword whose two LSBs are not 2'b11 starts a 16-bit instruction.
    function automatic logic is_compressed(input logic [15:0] halfword);
        return halfword[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/riscv_instr_aligner_if.sv
// Fetch-word input, branch redirect and instruction output of the aligner.
// The aligner takes the slave side; the prefetch buffer / ID stage take the master side.
interface riscv_instr_aligner_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  fetch_valid_i;
    logic                  fetch_ready_o;
    logic [31:0]           fetch_rdata_i;
    logic [ADDR_WIDTH-1:0] fetch_addr_i;
    logic                  branch_i;
    logic [ADDR_WIDTH-1:0] branch_addr_i;
    logic                  instr_valid_o;
    logic                  instr_ready_i;
    logic [31:0]           instr_o;
    logic                  instr_compressed_o;
    logic [ADDR_WIDTH-1:0] instr_pc_o;

    modport slave (
        input  fetch_valid_i, fetch_rdata_i, fetch_addr_i, branch_i, branch_addr_i,
               instr_ready_i,
        output fetch_ready_o, instr_valid_o, instr_o, instr_compressed_o, instr_pc_o
    );

    modport master (
        output fetch_valid_i, fetch_rdata_i, fetch_addr_i, branch_i, branch_addr_i,
               instr_ready_i,
        input  fetch_ready_o, instr_valid_o, instr_o, instr_compressed_o, instr_pc_o
    );
endinterface

// File: rtl/riscv_instr_aligner.sv
// Instruction aligner: one instruction per handshake from a word-aligned fetch stream,
// handling RVC, 32-bit instructions straddling two words and branch targets with pc[1]=1.
module riscv_instr_aligner
    import riscv_instr_aligner_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter bit RVC_EN     = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    riscv_instr_aligner_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] HALF_STEP = ADDR_WIDTH'(2);

    align_state_e          state_q, state_d;
    logic [15:0]           buf_q, buf_d;
    logic [ADDR_WIDTH-1:0] buf_pc_q, buf_pc_d;

    logic [15:0] word_lo, word_hi;
    logic        valid, fire;

    assign word_lo = bus.fetch_rdata_i[15:0];
    assign word_hi = bus.fetch_rdata_i[31:16];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ALIGNED;
            buf_q    <= '0;
            buf_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            buf_pc_q <= buf_pc_d;
        end
    end

    // NOTE: every output and next-state value gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        valid                  = 1'b0;
        fire                   = 1'b0;
        bus.fetch_ready_o      = 1'b0;
        bus.instr_o            = '0;
        bus.instr_compressed_o = 1'b0;
        bus.instr_pc_o         = bus.fetch_addr_i;
        state_d                = state_q;
        buf_d                  = buf_q;
        buf_pc_d               = buf_pc_q;

        if (!RVC_EN) begin
            valid             = bus.fetch_valid_i;
            fire              = valid && bus.instr_ready_i;
            bus.instr_o       = bus.fetch_rdata_i;
            bus.fetch_ready_o = fire;
            state_d           = ALIGNED;
        end else begin
            unique case (state_q)
                ALIGNED: begin
                    valid = bus.fetch_valid_i;
                    fire  = valid && bus.instr_ready_i;
                    if (!is_compressed(word_lo)) begin
                        bus.instr_o       = bus.fetch_rdata_i;
                        bus.fetch_ready_o = fire;
                    end else begin
                        bus.instr_o            = {16'h0, word_lo};
                        bus.instr_compressed_o = 1'b1;
                        if (fire) begin
                            bus.fetch_ready_o = 1'b1;
                            buf_d             = word_hi;
                            buf_pc_d          = bus.fetch_addr_i + HALF_STEP;
                            state_d           = is_compressed(word_hi) ? MIS16 : MIS32;
                        end
                    end
                end
                MIS32: begin
                    valid          = bus.fetch_valid_i;
                    fire           = valid && bus.instr_ready_i;
                    bus.instr_o    = {word_lo, buf_q};
                    bus.instr_pc_o = buf_pc_q;
                    if (fire) begin
                        bus.fetch_ready_o = 1'b1;
                        buf_d             = word_hi;
                        buf_pc_d          = bus.fetch_addr_i + HALF_STEP;
                        state_d           = is_compressed(word_hi) ? MIS16 : MIS32;
                    end
                end
                MIS16: begin
                    // The buffered RVC is self-contained; the fetch word waits untouched.
                    valid                  = 1'b1;
                    fire                   = bus.instr_ready_i;
                    bus.instr_o            = {16'h0, buf_q};
                    bus.instr_compressed_o = 1'b1;
                    bus.instr_pc_o         = buf_pc_q;
                    if (fire) state_d = ALIGNED;
                end
                BRMIS: begin
                    bus.instr_pc_o = bus.fetch_addr_i + HALF_STEP;
                    if (is_compressed(word_hi)) begin
                        valid                  = bus.fetch_valid_i;
                        fire                   = valid && bus.instr_ready_i;
                        bus.instr_o            = {16'h0, word_hi};
                        bus.instr_compressed_o = 1'b1;
                        if (fire) begin
                            bus.fetch_ready_o = 1'b1;
                            state_d           = ALIGNED;
                        end
                    end else if (bus.fetch_valid_i) begin
                        bus.fetch_ready_o = 1'b1;
                        buf_d             = word_hi;
                        buf_pc_d          = bus.fetch_addr_i + HALF_STEP;
                        state_d           = MIS32;
                    end
                end
                default: state_d = ALIGNED;
            endcase
        end

        // Redirect overrides any in-flight handshake, including a half-built straddle.
        if (bus.branch_i) begin
            valid             = 1'b0;
            bus.fetch_ready_o = 1'b0;
            buf_d             = '0;
            buf_pc_d          = '0;
            state_d           = (RVC_EN && bus.branch_addr_i[1]) ? BRMIS : ALIGNED;
        end

        if (rst) begin
            valid             = 1'b0;
            bus.fetch_ready_o = 1'b0;
        end

        bus.instr_valid_o = valid;
    end

endmodule

// File: tb/tb_riscv_instr_aligner.sv
// Directed self-checking bench for riscv_instr_aligner.
module tb_riscv_instr_aligner;
    import riscv_instr_aligner_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    riscv_instr_aligner_if #(.ADDR_WIDTH(32)) bus ();

    riscv_instr_aligner #(.ADDR_WIDTH(32), .RVC_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Move to just after the next rising edge; inputs are then driven and outputs sampled mid-cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [31:0] word, input logic [31:0] addr,
                         input logic rdy, input logic br, input logic [31:0] br_addr);
        bus.fetch_valid_i = fv;
        bus.fetch_rdata_i = word;
        bus.fetch_addr_i  = addr;
        bus.instr_ready_i = rdy;
        bus.branch_i      = br;
        bus.branch_addr_i = br_addr;
        #1;
    endtask

    task automatic expect_instr(input string tag, input logic vld, input logic [31:0] instr,
                                input logic [31:0] pc, input logic comp, input logic frdy);
        check({tag, ".valid"}, 64'(bus.instr_valid_o), 64'(vld));
        check({tag, ".fready"}, 64'(bus.fetch_ready_o), 64'(frdy));
        if (vld) begin
            check({tag, ".instr"}, 64'(bus.instr_o), 64'(instr));
            check({tag, ".pc"}, 64'(bus.instr_pc_o), 64'(pc));
            check({tag, ".comp"}, 64'(bus.instr_compressed_o), 64'(comp));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        next_cycle();

        // Reset holds both handshakes low even with a valid word and a ready consumer.
        drive(1'b1, 32'h0000_0013, 32'h100, 1'b1, 1'b0, 32'h0);
        expect_instr("reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b0;

        // 1: plain 32-bit stream
        drive(1'b1, 32'h0000_0013, 32'h100, 1'b1, 1'b0, 32'h0);
        expect_instr("t1a", 1'b1, 32'h0000_0013, 32'h100, 1'b0, 1'b1);
        next_cycle();
        drive(1'b1, 32'h0010_0093, 32'h104, 1'b1, 1'b0, 32'h0);
        expect_instr("t1b", 1'b1, 32'h0010_0093, 32'h104, 1'b0, 1'b1);
        next_cycle();

        // 2: two RVC in one word; second comes from the buffer without consuming fetch
        drive(1'b1, 32'h0001_0001, 32'h200, 1'b1, 1'b0, 32'h0);
        expect_instr("t2a", 1'b1, 32'h0000_0001, 32'h200, 1'b1, 1'b1);
        next_cycle();
        drive(1'b0, 32'h0, 32'h204, 1'b1, 1'b0, 32'h0);
        expect_instr("t2b", 1'b1, 32'h0000_0001, 32'h202, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 32'h204, 1'b1, 1'b0, 32'h0);
        expect_instr("t2c", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("t2c.state", 64'(dut.state_q), 64'(ALIGNED));
        next_cycle();

        // 3: RVC then a 32-bit instr straddling 0x302..0x305; upper half of 0x304 is RVC
        drive(1'b1, 32'h0093_0001, 32'h300, 1'b1, 1'b0, 32'h0);
        expect_instr("t3a", 1'b1, 32'h0000_0001, 32'h300, 1'b1, 1'b1);
        next_cycle();
        drive(1'b1, 32'h0000_0010, 32'h304, 1'b1, 1'b0, 32'h0);
        expect_instr("t3b", 1'b1, 32'h0010_0093, 32'h302, 1'b0, 1'b1);
        next_cycle();
        drive(1'b0, 32'h0, 32'h308, 1'b1, 1'b0, 32'h0);
        expect_instr("t3c", 1'b1, 32'h0000_0000, 32'h306, 1'b1, 1'b0);
        next_cycle();

        // 4: branch to 0x402 issues only the upper RVC of the word at 0x400
        drive(1'b1, 32'h0000_0013, 32'h308, 1'b1, 1'b1, 32'h402);
        expect_instr("t4br", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h0001_0013, 32'h400, 1'b1, 1'b0, 32'h0);
        expect_instr("t4a", 1'b1, 32'h0000_0001, 32'h402, 1'b1, 1'b1);
        next_cycle();
        // branch to 0x406 whose upper half starts a 32-bit instr: silent consume first
        drive(1'b1, 32'h0000_0013, 32'h404, 1'b1, 1'b1, 32'h406);
        expect_instr("t4br2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h0093_0001, 32'h404, 1'b1, 1'b0, 32'h0);
        expect_instr("t4b", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        next_cycle();
        drive(1'b1, 32'h0013_0010, 32'h408, 1'b1, 1'b0, 32'h0);
        expect_instr("t4c", 1'b1, 32'h0010_0093, 32'h406, 1'b0, 1'b1);
        next_cycle();

        // 5: stall in MIS32 (buffer 0x0013 @0x40a), then branch on the 2nd stall cycle
        drive(1'b1, 32'h0000_0000, 32'h40c, 1'b0, 1'b0, 32'h0);
        expect_instr("t5s1", 1'b1, 32'h0000_0013, 32'h40a, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h0000_0000, 32'h40c, 1'b0, 1'b1, 32'h500);
        expect_instr("t5br", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h0000_0013, 32'h500, 1'b0, 1'b0, 32'h0);
        expect_instr("t5s3", 1'b1, 32'h0000_0013, 32'h500, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'h0000_0013, 32'h500, 1'b1, 1'b0, 32'h0);
        expect_instr("t5go", 1'b1, 32'h0000_0013, 32'h500, 1'b0, 1'b1);
        next_cycle();

        // 6: reset while holding a buffered RVC
        drive(1'b1, 32'h0001_0001, 32'h600, 1'b1, 1'b0, 32'h0);
        expect_instr("t6a", 1'b1, 32'h0000_0001, 32'h600, 1'b1, 1'b1);
        next_cycle();
        check("t6.state", 64'(dut.state_q), 64'(MIS16));
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h604, 1'b1, 1'b0, 32'h0);
        expect_instr("t6rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h604, 1'b1, 1'b0, 32'h0);
        expect_instr("t6b", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("t6.state2", 64'(dut.state_q), 64'(ALIGNED));
        check("t6.buf", 64'(dut.buf_q), 64'h0);
        check("t6.bufpc", 64'(dut.buf_pc_q), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
